// File: rtl/pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline  |
// | Optional perf counters: define HAZARD_PERF_EN.    Rev 1.0                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int MULDIV_LAT   = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UseRs_ID,
  input  logic        UseRt_ID,
  input  logic        MemRead_IDEX,
  input  logic [4:0]  RegWriteAddr_IDEX,
  input  logic        BranchTaken_EX,
  input  logic        MulDivStart_EX,
  input  logic        MemWait,
  output logic        PC_Stall,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        ID_Stall,
  output logic        ID_Flush,
  output logic        EX_Stall,
  output logic        EX_Flush,
  output logic        MulDivBusy,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_MDBUSY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] START_INIT = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] MD_INIT    = CNT_W'(MULDIV_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             md_active;

  // $0 is hard-wired, so a load targeting it can never create a dependency
  assign load_use = MemRead_IDEX && (RegWriteAddr_IDEX != 5'd0) &&
                    ((UseRs_ID && (Rs_ID == RegWriteAddr_IDEX)) ||
                     (UseRt_ID && (Rt_ID == RegWriteAddr_IDEX)));

  assign md_active = (state_q == ST_MDBUSY) && (cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PC_Stall   = 1'b0;
    IF_Stall   = 1'b0;
    IF_Flush   = 1'b0;
    ID_Stall   = 1'b0;
    ID_Flush   = 1'b0;
    EX_Stall   = 1'b0;
    EX_Flush   = 1'b0;
    MulDivBusy = 1'b0;

    case (state_q)
      ST_RUN, ST_MDBUSY: begin
        if (MemWait) begin
          PC_Stall   = 1'b1;
          IF_Stall   = 1'b1;
          ID_Stall   = 1'b1;
          EX_Stall   = 1'b1;
          MulDivBusy = md_active;
        end else if (md_active) begin
          PC_Stall   = 1'b1;
          IF_Stall   = 1'b1;
          ID_Stall   = 1'b1;
          EX_Flush   = 1'b1;
          MulDivBusy = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
        end else begin
          // Release cycle of a mul/div behaves like RUN, but the op still in EX
          // must not retrigger its own sequence.
          if (state_q == ST_MDBUSY) begin
            state_d = ST_RUN;
          end
          if (BranchTaken_EX) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
          end else if ((state_q == ST_RUN) && MulDivStart_EX) begin
            PC_Stall   = 1'b1;
            IF_Stall   = 1'b1;
            ID_Stall   = 1'b1;
            EX_Flush   = 1'b1;
            MulDivBusy = 1'b1;
            cnt_d      = MD_INIT;
            state_d    = ST_MDBUSY;
          end else if (load_use) begin
            PC_Stall = 1'b1;
            IF_Stall = 1'b1;
            ID_Flush = 1'b1;
          end
        end
      end

      ST_START: begin
        PC_Stall = 1'b1;
        IF_Stall = 1'b1;
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        PC_Stall = 1'b1;
        IF_Stall = 1'b1;
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
        state_d  = ST_START;
        cnt_d    = START_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      cnt_q   <= START_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        post_start;

  assign post_start = (state_q == ST_RUN) || (state_q == ST_MDBUSY);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (post_start && PC_Stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (post_start && (IF_Flush || ID_Flush || EX_Flush)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (default parameters).
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  Rs_ID, Rt_ID, RegWriteAddr_IDEX;
  logic        UseRs_ID, UseRt_ID, MemRead_IDEX;
  logic        BranchTaken_EX, MulDivStart_EX, MemWait;
  logic        PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush;
  logic        EX_Stall, EX_Flush, MulDivBusy;
  logic [31:0] StallCount, FlushCount;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .Rs_ID             (Rs_ID),
    .Rt_ID             (Rt_ID),
    .UseRs_ID          (UseRs_ID),
    .UseRt_ID          (UseRt_ID),
    .MemRead_IDEX      (MemRead_IDEX),
    .RegWriteAddr_IDEX (RegWriteAddr_IDEX),
    .BranchTaken_EX    (BranchTaken_EX),
    .MulDivStart_EX    (MulDivStart_EX),
    .MemWait           (MemWait),
    .PC_Stall          (PC_Stall),
    .IF_Stall          (IF_Stall),
    .IF_Flush          (IF_Flush),
    .ID_Stall          (ID_Stall),
    .ID_Flush          (ID_Flush),
    .EX_Stall          (EX_Stall),
    .EX_Flush          (EX_Flush),
    .MulDivBusy        (MulDivBusy),
    .StallCount        (StallCount),
    .FlushCount        (FlushCount)
  );

  // Packed order: PC_Stall IF_Stall IF_Flush ID_Stall ID_Flush EX_Stall EX_Flush MulDivBusy
  logic [7:0] outs;
  assign outs = {PC_Stall, IF_Stall, IF_Flush, ID_Stall, ID_Flush, EX_Stall, EX_Flush, MulDivBusy};

  localparam logic [7:0] O_START = 8'b1110_1000;
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_BR    = 8'b0010_1000;
  localparam logic [7:0] O_MW    = 8'b1101_0100;
  localparam logic [7:0] O_MWMD  = 8'b1101_0101;
  localparam logic [7:0] O_MD    = 8'b1101_0011;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] wa;
    logic       br;
    logic       mw;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  bit          post = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic [4:0] wa,
                        input logic br, input logic md, input logic mw);
    Rs_ID = rs; Rt_ID = rt; UseRs_ID = urs; UseRt_ID = urt; MemRead_IDEX = mr;
    RegWriteAddr_IDEX = wa; BranchTaken_EX = br; MulDivStart_EX = md; MemWait = mw;
  endtask

  // One clock cycle: inputs already driven at posedge+1, outputs sampled at negedge.
  task automatic tick(input string name, input logic [7:0] exp);
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk({name, "_stallcnt"}, StallCount, exp_stall);
    chk({name, "_flushcnt"}, FlushCount, exp_flush);
`endif
    chk(name, {24'd0, outs}, {24'd0, exp});
    if (post) begin
      if (exp[7]) exp_stall++;
      if (exp[5] || exp[3] || exp[1]) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset at once, checks the in-reset outputs, then walks through START.
  task automatic do_reset(input string name);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk({name, "_rst_outs"}, {24'd0, outs}, {24'd0, O_START});
    chk({name, "_rst_stallcnt"}, StallCount, 32'd0);
    chk({name, "_rst_flushcnt"}, FlushCount, 32'd0);
    post = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick({name, "_start0"}, O_START);
    MemWait = 1'b1;
    tick({name, "_start1_mw_ignored"}, O_START);
    MemWait = 1'b0;
    post = 1'b1;
  endtask

  initial begin
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, O_IDLE};
    vecs[1]  = '{5'd5,  5'd2,  1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, O_LU};
    vecs[2]  = '{5'd0,  5'd2,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, O_IDLE};
    vecs[3]  = '{5'd1,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, O_LU};
    vecs[4]  = '{5'd1,  5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, O_IDLE};
    vecs[5]  = '{5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 5'd5,  1'b0, 1'b0, O_IDLE};
    vecs[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, O_BR};
    vecs[7]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, O_BR};
    vecs[8]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, O_MW};
    vecs[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, O_MW};
    vecs[10] = '{5'd3,  5'd9,  1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, O_LU};
    vecs[11] = '{5'd31, 5'd4,  1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, O_LU};

    #2;
    do_reset("init");
    tick("run_idle", O_IDLE);

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mr,
             vecs[i].wa, vecs[i].br, 1'b0, vecs[i].mw);
      tick($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Mul/div held in EX: 3 stalled cycles, release, then a back-to-back op.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick("md_start", O_MD);
    BranchTaken_EX = 1'b1;
    tick("md_busy_cnt2_br", O_MD);
    BranchTaken_EX = 1'b0;
    tick("md_busy_cnt1", O_MD);
    tick("md_release", O_IDLE);
    tick("md_b2b_start", O_MD);
    tick("md_b2b_cnt2", O_MD);
    tick("md_b2b_cnt1", O_MD);
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick("md_release_loaduse", O_LU);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick("md_after_idle", O_IDLE);

    // MemWait freezes MDBUSY at cnt=1 for two cycles.
    MulDivStart_EX = 1'b1;
    tick("mw_md_start", O_MD);
    tick("mw_md_cnt2", O_MD);
    MemWait = 1'b1;
    tick("mw_freeze0", O_MWMD);
    tick("mw_freeze1", O_MWMD);
    MemWait = 1'b0;
    tick("mw_resume_cnt1", O_MD);
    tick("mw_release", O_IDLE);
    MulDivStart_EX = 1'b0;
    tick("mw_after_idle", O_IDLE);

    // One load-use and one branch after a fresh START.
    do_reset("perf");
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick("perf_loaduse", O_LU);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick("perf_branch", O_BR);
    BranchTaken_EX = 1'b0;
    tick("perf_idle", O_IDLE);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_total", StallCount, 32'd1);
    chk("perf_flush_total", FlushCount, 32'd2);
`else
    chk("perf_stall_tied0", StallCount, 32'd0);
    chk("perf_flush_tied0", FlushCount, 32'd0);
`endif

    // Reset mid-MDBUSY aborts the sequence immediately.
    MulDivStart_EX = 1'b1;
    tick("abort_md_start", O_MD);
    tick("abort_md_cnt2", O_MD);
    do_reset("abort");
    tick("abort_run_idle", O_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
